mul_rr_scheduler: RTL and testbench

MUL_RR_SCHEDULER -- requirements
Module: mul_rr_scheduler

---
 rtl/mul_rr_scheduler_if.sv | 32 +++
 rtl/mul_rr_scheduler.sv | 138 +++++++++++++
 tb/tb_mul_rr_scheduler.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/mul_rr_scheduler_if.sv
// Request/response bundle between requesters, the scheduler and the shared multiplier_core.
// The slave modport is the scheduler's view; master is the environment driving it.
interface mul_rr_scheduler_if #(
  parameter int N_REQ = 4,
  parameter int W     = 4
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ*W-1:0] req_a;
  logic [N_REQ*W-1:0] req_b;
  logic [N_REQ-1:0]   req_ready;
  logic [W-1:0]       core_a;
  logic [W-1:0]       core_b;
  logic [2*W-1:0]     core_product;
  logic               rsp_valid;
  logic [2*W-1:0]     rsp_product;
  logic [ID_W-1:0]    rsp_id;
  logic               rsp_ready;
  logic               busy;
  logic [15:0]        op_count;

  modport slave (
    input  req_valid, req_a, req_b, core_product, rsp_ready,
    output req_ready, core_a, core_b, rsp_valid, rsp_product, rsp_id, busy, op_count
  );

  modport master (
    output req_valid, req_a, req_b, core_product, rsp_ready,
    input  req_ready, core_a, core_b, rsp_valid, rsp_product, rsp_id, busy, op_count
  );
endinterface

// File: rtl/mul_rr_scheduler.sv
// Round-robin arbiter sharing one combinational multiplier_core among N_REQ requesters.
// One operation every 3 cycles: IDLE (grant) -> CALC (capture product) -> RESP (handshake).
module mul_rr_scheduler #(
  parameter int N_REQ = 4,
  parameter int W     = 4
) (
  input  logic                clk,
  input  logic                rst,
  mul_rr_scheduler_if.slave   bus
);
  localparam int ID_W = $clog2(N_REQ);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [W-1:0]       op_a_r;
  logic [W-1:0]       op_b_r;
  logic [ID_W-1:0]    last_grant_r;
  logic [ID_W-1:0]    rsp_id_r;
  logic               rsp_valid_r;
  logic [2*W-1:0]     rsp_product_r;
  logic [15:0]        op_count_r;
  logic [ID_W-1:0]    grant_idx_s;
  logic               grant_found_s;
  logic [N_REQ-1:0]   grant_onehot_s;
  logic               take_s;
  logic               hs_s;

  // Index k positions after base, modulo N_REQ (base < N_REQ, 1 <= k <= N_REQ).
  function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int k);
    int sum;
    sum = int'(base) + k;
    return (sum >= N_REQ) ? ID_W'(sum - N_REQ) : ID_W'(sum);
  endfunction

  // Round-robin search: walk from farthest to nearest so the nearest valid requester wins.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = {ID_W{1'b0}};
    for (int k = N_REQ; k >= 1; k--) begin
      grant_idx_s   = bus.req_valid[rr_idx(last_grant_r, k)] ? rr_idx(last_grant_r, k) : grant_idx_s;
      grant_found_s = grant_found_s | bus.req_valid[rr_idx(last_grant_r, k)];
    end
    grant_onehot_s = {{(N_REQ-1){1'b0}}, 1'b1} << grant_idx_s;
  end

  // Next-state and handshake decode.
  always_comb begin
    state_nxt_s = state_r;
    take_s      = 1'b0;
    hs_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (grant_found_s) begin
          take_s      = 1'b1;
          state_nxt_s = ST_CALC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        state_nxt_s = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_valid_r && bus.rsp_ready) begin
          hs_s        = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand capture and round-robin pointer; last_grant doubles as the owner id of the operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a_r       <= {W{1'b0}};
      op_b_r       <= {W{1'b0}};
      last_grant_r <= ID_W'(N_REQ - 1);
    end else if (take_s) begin
      op_a_r       <= bus.req_a[int'(grant_idx_s)*W +: W];
      op_b_r       <= bus.req_b[int'(grant_idx_s)*W +: W];
      last_grant_r <= grant_idx_s;
    end
  end

  // Response registers: loaded in CALC, held through RESP until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_r   <= 1'b0;
      rsp_product_r <= {(2*W){1'b0}};
      rsp_id_r      <= {ID_W{1'b0}};
    end else if (state_r == ST_CALC) begin
      rsp_valid_r   <= 1'b1;
      rsp_product_r <= bus.core_product;
      rsp_id_r      <= last_grant_r;
    end else if (hs_s) begin
      rsp_valid_r   <= 1'b0;
    end
  end

  // Completed-response counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count_r <= 16'd0;
    end else if (hs_s) begin
      op_count_r <= op_count_r + 16'd1;
    end
  end

  // The accept strobe must be visible in the grant cycle itself, so it is decoded, and masked during reset.
  assign bus.req_ready   = (take_s && !rst) ? grant_onehot_s : {N_REQ{1'b0}};
  assign bus.core_a      = op_a_r;
  assign bus.core_b      = op_b_r;
  assign bus.rsp_valid   = rsp_valid_r;
  assign bus.rsp_product = rsp_product_r;
  assign bus.rsp_id      = rsp_id_r;
  assign bus.busy        = (state_r != ST_IDLE);
  assign bus.op_count    = op_count_r;
endmodule

// File: tb/tb_mul_rr_scheduler.sv
// Directed bench for mul_rr_scheduler (N_REQ=4, W=4) with a behavioural multiplier_core.
module tb_mul_rr_scheduler;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  logic [3:0] op_a_tbl [4] = '{4'd1, 4'd3, 4'd7, 4'd15};
  logic [3:0] op_b_tbl [4] = '{4'd2, 4'd4, 4'd9, 4'd14};
  logic [7:0] prod_tbl [4] = '{8'd2, 8'd12, 8'd63, 8'd210};

  mul_rr_scheduler_if #(.N_REQ(4), .W(4)) bus ();

  mul_rr_scheduler #(.N_REQ(4), .W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.core_product = 8'(bus.core_a) * 8'(bus.core_b);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    n_checks++;
    if (got === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp_v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ops();
    for (int i = 0; i < 4; i++) begin
      bus.req_a[i*4 +: 4] = op_a_tbl[i];
      bus.req_b[i*4 +: 4] = op_b_tbl[i];
    end
  endtask

  // Called in an IDLE cycle with inputs settled; leaves the bench in the first RESP cycle.
  task automatic expect_op(input string tag, input logic [3:0] exp_ready,
                           input logic [1:0] exp_id, input logic [7:0] exp_prod);
    check_eq($sformatf("%s grant", tag), 32'(bus.req_ready), 32'(exp_ready));
    step();
    check_eq($sformatf("%s calc_ready", tag), 32'(bus.req_ready), 32'd0);
    check_eq($sformatf("%s calc_busy", tag), 32'(bus.busy), 32'd1);
    check_eq($sformatf("%s calc_valid", tag), 32'(bus.rsp_valid), 32'd0);
    step();
    check_eq($sformatf("%s rsp_valid", tag), 32'(bus.rsp_valid), 32'd1);
    check_eq($sformatf("%s rsp_product", tag), 32'(bus.rsp_product), 32'(exp_prod));
    check_eq($sformatf("%s rsp_id", tag), 32'(bus.rsp_id), 32'(exp_id));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq($sformatf("%s req_ready", tag), 32'(bus.req_ready), 32'd0);
    check_eq($sformatf("%s rsp_valid", tag), 32'(bus.rsp_valid), 32'd0);
    check_eq($sformatf("%s rsp_product", tag), 32'(bus.rsp_product), 32'd0);
    check_eq($sformatf("%s rsp_id", tag), 32'(bus.rsp_id), 32'd0);
    check_eq($sformatf("%s core_a", tag), 32'(bus.core_a), 32'd0);
    check_eq($sformatf("%s core_b", tag), 32'(bus.core_b), 32'd0);
    check_eq($sformatf("%s op_count", tag), 32'(bus.op_count), 32'd0);
    check_eq($sformatf("%s busy", tag), 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rr_ready;

    // Reset with every requester asking: nothing may be granted.
    rst           = 1'b1;
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b0;
    load_ops();
    #2;
    check_reset_outputs("reset");
    step();
    step();
    rst           = 1'b0;
    bus.req_valid = 4'b0000;

    // Single max-operand request from requester 0.
    bus.req_a[3:0] = 4'd15;
    bus.req_b[3:0] = 4'd15;
    bus.req_valid  = 4'b0001;
    bus.rsp_ready  = 1'b1;
    #1;
    expect_op("single", 4'b0001, 2'd0, 8'hE1);
    bus.req_valid = 4'b0000;
    step();
    check_eq("single op_count", 32'(bus.op_count), 32'd1);
    check_eq("single done_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("single done_busy", 32'(bus.busy), 32'd0);
    check_eq("single core_a_hold", 32'(bus.core_a), 32'd15);

    // Fresh reset, then all requesters held: back-to-back grants 0,1,2,3,0.
    rst = 1'b1;
    #1;
    rst = 1'b0;
    load_ops();
    bus.req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      rr_ready = 4'b0001 << (k % 4);
      expect_op($sformatf("rr%0d", k), rr_ready, 2'(k % 4), prod_tbl[k % 4]);
      step();
    end
    check_eq("rr op_count", 32'(bus.op_count), 32'd5);

    // Downstream stall in RESP with every requester asking.
    bus.req_valid = 4'b0100;
    bus.rsp_ready = 1'b0;
    #1;
    expect_op("stall", 4'b0100, 2'd2, 8'd63);
    bus.req_valid = 4'b1111;
    #1;
    for (int c = 0; c < 5; c++) begin
      check_eq($sformatf("stall%0d valid", c), 32'(bus.rsp_valid), 32'd1);
      check_eq($sformatf("stall%0d product", c), 32'(bus.rsp_product), 32'd63);
      check_eq($sformatf("stall%0d id", c), 32'(bus.rsp_id), 32'd2);
      check_eq($sformatf("stall%0d ready", c), 32'(bus.req_ready), 32'd0);
      check_eq($sformatf("stall%0d op_count", c), 32'(bus.op_count), 32'd5);
      step();
    end
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b0000;
    step();
    check_eq("stall op_count", 32'(bus.op_count), 32'd6);
    check_eq("stall released", 32'(bus.rsp_valid), 32'd0);

    // Pointer after 2: wrap past 3 to 0, and 3 when it alone asks; withdrawn requests are dropped.
    bus.req_valid = 4'b0011;
    #1;
    check_eq("rr wrap grant", 32'(bus.req_ready), 32'b0001);
    bus.req_valid = 4'b1000;
    #1;
    check_eq("rr next grant", 32'(bus.req_ready), 32'b1000);
    bus.req_valid = 4'b0000;
    #1;
    check_eq("idle no ready", 32'(bus.req_ready), 32'd0);
    step();
    check_eq("dropped busy", 32'(bus.busy), 32'd0);
    check_eq("dropped count", 32'(bus.op_count), 32'd6);

    // Reset while requester 2 is in CALC.
    bus.req_valid = 4'b0100;
    #1;
    check_eq("midrst grant", 32'(bus.req_ready), 32'b0100);
    step();
    bus.req_valid = 4'b0101;
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    step();
    rst = 1'b0;
    #1;
    expect_op("postrst", 4'b0001, 2'd0, 8'd2);
    bus.req_valid = 4'b0000;
    step();
    check_eq("postrst op_count", 32'(bus.op_count), 32'd1);

    // Start the counter just below its wrap point.
    force dut.op_count_r = 16'hFFFE;
    #1;
    release dut.op_count_r;
    bus.req_valid = 4'b0010;
    #1;
    expect_op("wrap1", 4'b0010, 2'd1, 8'd12);
    bus.req_valid = 4'b0000;
    step();
    check_eq("wrap op_count_ffff", 32'(bus.op_count), 32'hFFFF);
    bus.req_valid = 4'b1000;
    #1;
    expect_op("wrap2", 4'b1000, 2'd3, 8'd210);
    bus.req_valid = 4'b0000;
    step();
    check_eq("wrap op_count_0", 32'(bus.op_count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
